// File: rtl/inv_shift_rows_stream_if.sv
// Byte stream bundle (valid/ready/data/last) shared by the input and output
// sides of inv_shift_rows_stream.
interface inv_shift_rows_stream_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows with two ping-pong 16-byte banks.
// Bytes arrive column-major; they leave in inverse-shifted order at up to
// 1 byte/cycle once the first bank has filled.
// Optional feature macro: INV_SR_ADDKEY_EN adds a round_key port and XORs
// the per-block captured key into the output bytes.
module inv_shift_rows_stream (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef INV_SR_ADDKEY_EN
    input  logic [127:0]            i_round_key,
`endif
    inv_shift_rows_stream_if.slave  i_in,
    inv_shift_rows_stream_if.master o_out
);
    localparam int unsigned BYTES = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned KW    = 128;

    logic [DW-1:0] r_bank [2][BYTES];
    logic          r_wb;
    logic          r_rb;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_rcnt;
    logic [1:0]    r_full;

    logic          w_in_ready;
    logic          w_in_fire;
    logic          w_out_valid;
    logic          w_out_fire;
    logic [1:0]    w_row;
    logic [1:0]    w_col;
    logic [CW-1:0] w_src;
    logic [DW-1:0] w_byte;
    logic          w_unused_last;

    // Input-side last carries no meaning here; blocks are delimited by count.
    assign w_unused_last = i_in.last;

    assign w_in_ready  = !r_full[r_wb];
    assign w_in_fire   = i_in.valid && w_in_ready;
    assign w_out_valid = r_full[r_rb];
    assign w_out_fire  = w_out_valid && o_out.ready;

    // Output byte (r,c) comes from input byte (r, (c-r) mod 4).
    assign w_row = r_rcnt[1:0];
    assign w_col = 2'(r_rcnt[3:2] - r_rcnt[1:0]);
    assign w_src = {w_col, w_row};

`ifdef INV_SR_ADDKEY_EN
    logic [KW-1:0] r_key [2];

    // Capture the round key with input byte 0 so it stays fixed for the block.
    always_ff @(posedge clk) begin
        if (w_in_fire && (r_wcnt == '0)) begin
            r_key[r_wb] <= i_round_key;
        end
    end

    assign w_byte = r_bank[r_rb][w_src]
                  ^ DW'(r_key[r_rb] >> {4'(BYTES - 1) - r_rcnt, 3'b000});
`else
    logic [KW-1:0] w_unused_kw;
    assign w_unused_kw = '0;
    assign w_byte      = r_bank[r_rb][w_src];
`endif

    // Bank storage is not reset; the full flags alone qualify its contents.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_bank[r_wb][r_wcnt] <= i_in.data;
        end
    end

    // Pointer, counter and full-flag bookkeeping for both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wcnt <= '0;
            r_rcnt <= '0;
            r_full <= '0;
        end else begin
            if (w_in_fire) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == CW'(BYTES - 1)) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                end
            end
            if (w_out_fire) begin
                r_rcnt <= r_rcnt + 1'b1;
                if (r_rcnt == CW'(BYTES - 1)) begin
                    r_full[r_rb] <= 1'b0;
                    r_rb         <= ~r_rb;
                end
            end
        end
    end

    assign i_in.ready  = w_in_ready;
    assign o_out.valid = w_out_valid;
    assign o_out.last  = w_out_valid && (r_rcnt == CW'(BYTES - 1));
    assign o_out.data  = w_out_valid ? w_byte : '0;
endmodule
